// File: rtl/wisc_perf_monitor.sv
// Retire/cache event counters gated by an IDLE/RUN/HALTED FSM, with a registered read port.
// Optional shadow snapshot set enabled by defining PERF_SNAPSHOT_EN.
module wisc_perf_monitor #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr,
    input  logic             reg_write,
    input  logic             mem_write,
    input  logic             halt,
    input  logic             icache_req,
    input  logic             icache_hit,
    input  logic             dcache_req,
    input  logic             dcache_hit,
    input  logic             snap,
    input  logic [3:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             running,
    output logic             halted,
    output logic             err
);

    localparam int              NUM_CNT = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] cnt_d [NUM_CNT];
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             running_q, running_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;
    logic [NUM_CNT-1:0] inc;
    logic [CNT_W-1:0] status;

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow_q [NUM_CNT];
    logic [CNT_W-1:0] shadow_d [NUM_CNT];
`else
    logic unused_snapshot_inputs;
    assign unused_snapshot_inputs = ^{snap, rd_sel[3]};
`endif

    // Per-counter increment requests; index order matches the read map.
    always_comb begin
        inc[0] = 1'b1;
        inc[1] = halt | reg_write | mem_write;
        inc[2] = icache_req;
        inc[3] = icache_hit & icache_req;
        inc[4] = dcache_req;
        inc[5] = dcache_hit & dcache_req;
        inc[6] = mem_write;
    end

    assign status = {{(CNT_W-3){1'b0}}, err_q, halted_q, running_q};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (halt)  state_d = HALTED;
                HALTED:  state_d = HALTED;
                default: state_d = IDLE;
            endcase
        end

        running_d = (state_d == RUN);
        halted_d  = (state_d == HALTED);
        err_d     = clr ? 1'b0
                        : err_q | (icache_hit & ~icache_req) | (dcache_hit & ~dcache_req);

        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (state_q == RUN && inc[i] && cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

`ifdef PERF_SNAPSHOT_EN
    // Snapshot takes the pre-increment live values; clr wins over snap.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            shadow_d[i] = shadow_q[i];
            if (clr) begin
                shadow_d[i] = '0;
            end else if (snap) begin
                shadow_d[i] = cnt_q[i];
            end
        end
    end
`endif

    always_comb begin
        rd_data_d = status;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel[2:0] == 3'(i)) begin
`ifdef PERF_SNAPSHOT_EN
                rd_data_d = rd_sel[3] ? shadow_q[i] : cnt_q[i];
`else
                rd_data_d = cnt_q[i];
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rd_data_q <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            // NOTE: the counter array is real state read back over the port, so it is reset like any other flop.
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            running_q <= running_d;
            halted_q  <= halted_d;
            err_q     <= err_d;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef PERF_SNAPSHOT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end
`endif

    assign rd_data = rd_data_q;
    assign running = running_q;
    assign halted  = halted_q;
    assign err     = err_q;

endmodule

// File: tb/tb_wisc_perf_monitor.sv
// Self-checking bench for wisc_perf_monitor: directed vector table, corner sequences and
// randomized traffic against a count-based model; a 4-bit instance exercises saturation.
module tb_wisc_perf_monitor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start, clr, reg_write, mem_write, halt;
    logic icache_req, icache_hit, dcache_req, dcache_hit, snap;
    logic [3:0]  rd_sel;
    logic [15:0] rd_data;
    logic [3:0]  rd_data4;
    logic running, halted, err;
    logic running4, halted4, err4;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PERF_SNAPSHOT_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    wisc_perf_monitor #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .reg_write(reg_write),
        .mem_write(mem_write), .halt(halt), .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit), .snap(snap), .rd_sel(rd_sel),
        .rd_data(rd_data), .running(running), .halted(halted), .err(err)
    );

    wisc_perf_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .reg_write(reg_write),
        .mem_write(mem_write), .halt(halt), .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit), .snap(snap), .rd_sel(rd_sel),
        .rd_data(rd_data4), .running(running4), .halted(halted4), .err(err4)
    );

    typedef struct {
        bit       start, clr, rw, mw, halt, icr, ich, dcr, dch, snap;
        bit [3:0] sel;
    } stim_t;

    typedef struct {
        stim_t   s;
        longint  exp_rd;
        bit      exp_run, exp_halt, exp_err;
    } vec_t;

    // Model: unbounded event counts, saturated only when compared against a given width.
    longint m_cnt [7];
    longint m_shadow [7];
    int     m_mode;   // 0 idle, 1 run, 2 halted
    bit     m_err;
    longint m_rd;

    function automatic longint sat(input longint x, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    function automatic stim_t st(input bit start_i, input bit clr_i, input bit rw_i, input bit mw_i,
                                 input bit halt_i, input bit icr_i, input bit ich_i, input bit dcr_i,
                                 input bit dch_i, input bit snap_i, input bit [3:0] sel_i);
        stim_t s;
        s.start = start_i; s.clr = clr_i; s.rw = rw_i; s.mw = mw_i; s.halt = halt_i;
        s.icr = icr_i; s.ich = ich_i; s.dcr = dcr_i; s.dch = dch_i; s.snap = snap_i; s.sel = sel_i;
        return s;
    endfunction

    function automatic stim_t idle_sel(input bit [3:0] sel_i);
        return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, sel_i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            m_cnt[i] = 0;
            m_shadow[i] = 0;
        end
        m_mode = 0;
        m_err  = 1'b0;
        m_rd   = 0;
    endtask

    task automatic model_step(input stim_t s);
        int idx = int'(s.sel[2:0]);
        if (idx == 7)
            m_rd = (m_err ? 4 : 0) + (m_mode == 2 ? 2 : 0) + (m_mode == 1 ? 1 : 0);
        else if (SNAP_EN && s.sel[3])
            m_rd = m_shadow[idx];
        else
            m_rd = m_cnt[idx];

        if (s.clr) begin
            for (int i = 0; i < 7; i++) begin
                m_cnt[i] = 0;
                m_shadow[i] = 0;
            end
            m_mode = 0;
            m_err  = 1'b0;
            return;
        end
        if ((s.ich && !s.icr) || (s.dch && !s.dcr)) m_err = 1'b1;
        if (SNAP_EN && s.snap) m_shadow = m_cnt;
        if (m_mode == 1) begin
            m_cnt[0] += 1;
            if (s.halt || s.rw || s.mw) m_cnt[1] += 1;
            if (s.icr)          m_cnt[2] += 1;
            if (s.icr && s.ich) m_cnt[3] += 1;
            if (s.dcr)          m_cnt[4] += 1;
            if (s.dcr && s.dch) m_cnt[5] += 1;
            if (s.mw)           m_cnt[6] += 1;
            if (s.halt) m_mode = 2;
        end else if (m_mode == 0 && s.start) begin
            m_mode = 1;
        end
    endtask

    task automatic compare_model();
        check("rd16", 64'(rd_data), sat(m_rd, 16));
        check("rd4", 64'(rd_data4), sat(m_rd, 4));
        check("running", {63'b0, running}, {63'b0, m_mode == 1});
        check("halted", {63'b0, halted}, {63'b0, m_mode == 2});
        check("err", {63'b0, err}, {63'b0, m_err});
        check("status4", {61'b0, err4, halted4, running4}, {61'b0, err, halted, running});
    endtask

    // Called at a negedge: drive, clock, update model, then compare at the next negedge.
    task automatic step(input stim_t s);
        start = s.start; clr = s.clr; reg_write = s.rw; mem_write = s.mw; halt = s.halt;
        icache_req = s.icr; icache_hit = s.ich; dcache_req = s.dcr; dcache_hit = s.dch;
        snap = s.snap; rd_sel = s.sel;
        @(posedge clk);
        model_step(s);
        @(negedge clk);
        compare_model();
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;

        start = 0; clr = 0; reg_write = 0; mem_write = 0; halt = 0;
        icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0; snap = 0; rd_sel = 0;
        model_reset();

        // Directed table: run/halt/freeze, clr with events, err from an unqualified hit.
        v = '{s: st(1,0,0,0,0,0,0,0,0,0,4'd0), exp_rd: 0, exp_run: 1, exp_halt: 0, exp_err: 0};
        tbl.push_back(v);
        for (int k = 1; k <= 10; k++) begin
            v = '{s: st(0,0,1,0,0,0,0,0,0,0,4'd0), exp_rd: k-1, exp_run: 1, exp_halt: 0, exp_err: 0};
            tbl.push_back(v);
        end
        v = '{s: st(0,0,0,0,1,0,0,0,0,0,4'd1), exp_rd: 10, exp_run: 0, exp_halt: 1, exp_err: 0};
        tbl.push_back(v);
        v = '{s: st(0,0,1,1,0,1,0,0,0,0,4'd0), exp_rd: 11, exp_run: 0, exp_halt: 1, exp_err: 0};
        tbl.push_back(v);
        v = '{s: st(0,0,1,0,1,0,0,1,0,0,4'd1), exp_rd: 11, exp_run: 0, exp_halt: 1, exp_err: 0};
        tbl.push_back(v);
        v = '{s: idle_sel(4'd6), exp_rd: 0, exp_run: 0, exp_halt: 1, exp_err: 0};
        tbl.push_back(v);
        v = '{s: idle_sel(4'd7), exp_rd: 2, exp_run: 0, exp_halt: 1, exp_err: 0};
        tbl.push_back(v);
        v = '{s: st(0,1,1,0,1,0,0,0,0,0,4'd0), exp_rd: 11, exp_run: 0, exp_halt: 0, exp_err: 0};
        tbl.push_back(v);
        v = '{s: idle_sel(4'd0), exp_rd: 0, exp_run: 0, exp_halt: 0, exp_err: 0};
        tbl.push_back(v);
        v = '{s: idle_sel(4'd7), exp_rd: 0, exp_run: 0, exp_halt: 0, exp_err: 0};
        tbl.push_back(v);
        v = '{s: st(1,0,0,0,0,0,0,0,1,0,4'd5), exp_rd: 0, exp_run: 1, exp_halt: 0, exp_err: 1};
        tbl.push_back(v);
        v = '{s: idle_sel(4'd5), exp_rd: 0, exp_run: 1, exp_halt: 0, exp_err: 1};
        tbl.push_back(v);
        v = '{s: idle_sel(4'd7), exp_rd: 5, exp_run: 1, exp_halt: 0, exp_err: 1};
        tbl.push_back(v);
        v = '{s: st(0,1,0,0,0,0,0,0,0,0,4'd0), exp_rd: 2, exp_run: 0, exp_halt: 0, exp_err: 0};
        tbl.push_back(v);

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_rd", 64'(rd_data), 64'd0);
        check("reset_running", {63'b0, running}, 64'd0);
        check("reset_halted", {63'b0, halted}, 64'd0);
        check("reset_err", {63'b0, err}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            step(tbl[i].s);
            check($sformatf("tbl%0d_rd", i), 64'(rd_data), 64'(tbl[i].exp_rd));
            check($sformatf("tbl%0d_run", i), {63'b0, running}, {63'b0, tbl[i].exp_run});
            check($sformatf("tbl%0d_halt", i), {63'b0, halted}, {63'b0, tbl[i].exp_halt});
            check($sformatf("tbl%0d_err", i), {63'b0, err}, {63'b0, tbl[i].exp_err});
        end

        // Cache request/hit counts.
        step(st(1,0,0,0,0,0,0,0,0,0,4'd0));
        for (int i = 0; i < 8; i++)
            step(st(0,0,0,0,0,1,i<5,i<4,i<3,0,4'd0));
        step(idle_sel(4'd2)); check("ireq", 64'(rd_data), 64'd8);
        step(idle_sel(4'd3)); check("ihit", 64'(rd_data), 64'd5);
        step(idle_sel(4'd4)); check("dreq", 64'(rd_data), 64'd4);
        step(idle_sel(4'd5)); check("dhit", 64'(rd_data), 64'd3);
        check("cache_err", {63'b0, err}, 64'd0);

        // Saturation of the 4-bit instance.
        step(st(0,1,0,0,0,0,0,0,0,0,4'd0));
        step(st(1,0,0,0,0,0,0,0,0,0,4'd0));
        for (int k = 0; k < 20; k++) begin
            step(idle_sel(4'd0));
            check($sformatf("sat4_c%0d", k), 64'(rd_data4), 64'((k > 15) ? 15 : k));
        end
        step(idle_sel(4'd0));
        check("cyc16_no_sat", 64'(rd_data), 64'd20);

        // Snapshot: capture at idx0=7, five more RUN cycles ending in halt.
        step(st(0,1,0,0,0,0,0,0,0,0,4'd0));
        step(st(1,0,0,0,0,0,0,0,0,0,4'd0));
        repeat (7) step(idle_sel(4'd0));
        step(st(0,0,0,0,0,0,0,0,0,1,4'd0));
        repeat (3) step(idle_sel(4'd0));
        step(st(0,0,0,0,1,0,0,0,0,0,4'd0));
        step(idle_sel(4'h8)); check("snap_shadow", 64'(rd_data), SNAP_EN ? 64'd7 : 64'd12);
        step(idle_sel(4'h0)); check("snap_live", 64'(rd_data), 64'd12);
        step(st(0,1,0,0,0,0,0,0,0,1,4'd0));
        step(idle_sel(4'h8)); check("snap_clr", 64'(rd_data), 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            stim_t s;
            s.clr   = ($urandom_range(0, 39) == 0);
            s.start = ($urandom_range(0, 3) == 0);
            s.halt  = ($urandom_range(0, 29) == 0);
            s.rw    = 1'($urandom); s.mw  = 1'($urandom);
            s.icr   = 1'($urandom); s.ich = 1'($urandom);
            s.dcr   = 1'($urandom); s.dch = ($urandom_range(0, 15) == 0) ? 1'b1 : s.dcr & 1'($urandom);
            s.ich   = ($urandom_range(0, 15) == 0) ? 1'b1 : s.icr & s.ich;
            s.snap  = ($urandom_range(0, 7) == 0);
            s.sel   = 4'($urandom);
            step(s);
        end

        // Asynchronous reset in the middle of RUN.
        step(st(0,1,0,0,0,0,0,0,0,0,4'd0));
        step(st(1,0,0,0,0,0,0,0,0,0,4'd0));
        repeat (4) step(st(0,0,1,1,0,1,1,1,1,0,4'd1));
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("arst_rd", 64'(rd_data), 64'd0);
        check("arst_running", {63'b0, running}, 64'd0);
        check("arst_err", {63'b0, err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step(idle_sel(4'd1));
        check("arst_cnt", 64'(rd_data), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
